// File: rtl/dffram_1r1w.sv
// Two-port byte-masked DFF RAM: one write port, one independent read port, write-first
// collision bypass, optional output register and a post-reset zero-clear sequencer.
module dffram_1r1w #(
    parameter int WSIZE      = 4,
    parameter int WORDS      = 64,
    parameter bit OREG       = 1'b0,
    parameter bit CLR_ON_RST = 1'b1,
    localparam int DW = 8 * WSIZE,
    localparam int AW = $clog2(WORDS)
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             EN0,
    input  logic [WSIZE-1:0] WE0,
    input  logic [AW-1:0]    A0,
    input  logic [DW-1:0]    Di0,
    input  logic             EN1,
    input  logic [AW-1:0]    A1,
    output logic [DW-1:0]    Do1,
    output logic             VLD1,
    output logic             BUSY
);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    localparam state_t RST_STATE = CLR_ON_RST ? ST_CLEAR : ST_IDLE;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   mem_q [WORDS];

    logic            busy;
    logic [AW-1:0]   wr_addr;
    logic [WSIZE-1:0] wr_mask;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   wr_word;
    logic            wr_en;
    logic            rd_req;
    logic [DW-1:0]   rd_word;
    logic [DW-1:0]   do_q, do_d;
    logic            vld_q, vld_d;

    assign busy = (state_q == ST_CLEAR);
    assign BUSY = busy;
    assign Do1  = do_q;
    assign VLD1 = vld_q;

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(WORDS - 1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The clear sequencer takes over the write port; the merged word also feeds the bypass.
    always_comb begin
        wr_addr = A0;
        wr_mask = EN0 ? WE0 : '0;
        wr_data = Di0;
        if (busy) begin
            wr_addr = cnt_q;
            wr_mask = '1;
            wr_data = '0;
        end
        wr_en = |wr_mask;
        for (int i = 0; i < WSIZE; i++) begin
            wr_word[8*i +: 8] = wr_mask[i] ? wr_data[8*i +: 8] : mem_q[wr_addr][8*i +: 8];
        end
    end

    // NOTE: the storage array is deliberately not reset; only the clear sequence zeroes it.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    always_comb begin
        rd_req  = EN1 && !busy;
        rd_word = (wr_en && (wr_addr == A1)) ? wr_word : mem_q[A1];
    end

    generate
        if (OREG) begin : g_oreg
            logic          pipe_vld_q, pipe_vld_d;
            logic [DW-1:0] pipe_data_q, pipe_data_d;

            always_comb begin
                pipe_vld_d  = rd_req;
                pipe_data_d = rd_req ? rd_word : pipe_data_q;
                vld_d       = pipe_vld_q;
                do_d        = pipe_vld_q ? pipe_data_q : do_q;
            end

            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    pipe_vld_q  <= 1'b0;
                    pipe_data_q <= '0;
                end else begin
                    pipe_vld_q  <= pipe_vld_d;
                    pipe_data_q <= pipe_data_d;
                end
            end
        end else begin : g_direct
            always_comb begin
                vld_d = rd_req;
                do_d  = rd_req ? rd_word : do_q;
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            do_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            do_q  <= do_d;
            vld_q <= vld_d;
        end
    end

endmodule

// File: tb/tb_dffram_1r1w.sv
// Scoreboard bench for dffram_1r1w: an OREG=0 and an OREG=1 instance share the same
// stimulus; per-instance monitors pop expected words and check data and latency on VLD1.
module tb_dffram_1r1w;

    typedef struct {
        logic [31:0] data;
        int          issue;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en0;
    logic [3:0]  we0;
    logic [5:0]  a0;
    logic [31:0] di0;
    logic        en1;
    logic [5:0]  a1;
    logic [31:0] do_a, do_b;
    logic        vld_a, vld_b, busy_a, busy_b;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dffram_1r1w #(.WSIZE(4), .WORDS(64), .OREG(1'b0), .CLR_ON_RST(1'b1)) u_dut_a (
        .CLK(clk), .RESETn(rst_n), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0),
        .EN1(en1), .A1(a1), .Do1(do_a), .VLD1(vld_a), .BUSY(busy_a)
    );

    dffram_1r1w #(.WSIZE(4), .WORDS(64), .OREG(1'b1), .CLR_ON_RST(1'b1)) u_dut_b (
        .CLK(clk), .RESETn(rst_n), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0),
        .EN1(en1), .A1(a1), .Do1(do_b), .VLD1(vld_b), .BUSY(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && vld_a) begin
            if (q_a.size() == 0) begin
                check("spurious_vld_oreg0", {31'b0, vld_a}, 32'h0);
            end else begin
                e_a = q_a.pop_front();
                check("rdata_oreg0", do_a, e_a.data);
                check("rlat_oreg0", cyc, e_a.issue + 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && vld_b) begin
            if (q_b.size() == 0) begin
                check("spurious_vld_oreg1", {31'b0, vld_b}, 32'h0);
            end else begin
                e_b = q_b.pop_front();
                check("rdata_oreg1", do_b, e_b.data);
                check("rlat_oreg1", cyc, e_b.issue + 2);
            end
        end
    end

    task automatic step(input logic e0, input logic [3:0] w, input logic [5:0] wa,
                        input logic [31:0] wd, input logic e1, input logic [5:0] ra,
                        input logic [31:0] exp);
        exp_t t;
        en0 = e0; we0 = w; a0 = wa; di0 = wd;
        en1 = e1; a1 = ra;
        if (e1) begin
            t.data  = exp;
            t.issue = cyc;
            q_a.push_back(t);
            q_b.push_back(t);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [3:0] w, input logic [31:0] d);
        step(1'b1, w, a, d, 1'b0, 6'd0, 32'h0);
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp);
        step(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, a, exp);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 10 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        check({tag, "_pending_oreg0"}, q_a.size(), 32'd0);
        check({tag, "_pending_oreg1"}, q_b.size(), 32'd0);
        q_a.delete();
        q_b.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        en0 = 1'b0; we0 = '0; a0 = '0; di0 = '0; en1 = 1'b0; a1 = '0;
        repeat (3) @(negedge clk);

        check("rst_do_oreg0", do_a, 32'h0);
        check("rst_do_oreg1", do_b, 32'h0);
        check("rst_vld_oreg0", {31'b0, vld_a}, 32'h0);
        check("rst_vld_oreg1", {31'b0, vld_b}, 32'h0);
        check("rst_busy_oreg0", {31'b0, busy_a}, 32'h1);
        check("rst_busy_oreg1", {31'b0, busy_b}, 32'h1);

        // Clear after release, with a read request held throughout.
        en1 = 1'b1;
        a1  = 6'd5;
        rst_n = 1'b1;
        n = 0;
        while (busy_a && n < 200) begin
            n++;
            @(negedge clk);
        end
        en1 = 1'b0;
        check("clear_busy_cycles", n, 32'd64);
        check("clear_busy_oreg1", {31'b0, busy_b}, 32'h0);
        check("clear_do_held_oreg0", do_a, 32'h0);
        check("clear_do_held_oreg1", do_b, 32'h0);
        for (int i = 0; i < 64; i++) rd(6'(i), 32'h0);
        idle();
        drain("clear");

        // Byte masks.
        wr(6'd2, 4'b1111, 32'hAA0055BB);
        wr(6'd2, 4'b0100, 32'h00330000);
        rd(6'd2, 32'hAA3355BB);
        idle();
        // Independent access to different addresses in the same cycle.
        step(1'b1, 4'b1111, 6'd8, 32'h55555555, 1'b1, 6'd2, 32'hAA3355BB);
        rd(6'd8, 32'h55555555);
        idle();
        drain("mask");

        // Write-first collision, per byte.
        wr(6'd7, 4'b1111, 32'h11223344);
        step(1'b1, 4'b0011, 6'd7, 32'hAABBCCDD, 1'b1, 6'd7, 32'h1122CCDD);
        rd(6'd7, 32'h1122CCDD);
        step(1'b1, 4'b0000, 6'd7, 32'hFFFFFFFF, 1'b1, 6'd7, 32'h1122CCDD);
        idle();
        drain("collision");

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) wr(6'(i), 4'b1111, 32'h10 + 32'(i));
        for (int i = 0; i < 4; i++) rd(6'(i), 32'h10 + 32'(i));
        idle();
        drain("pipeline");
        repeat (3) idle();
        check("hold_do_oreg0", do_a, 32'h13);
        check("hold_do_oreg1", do_b, 32'h13);

        // Top address against address 0.
        wr(6'd63, 4'b1111, 32'hDEADBEEF);
        wr(6'd0, 4'b1111, 32'h01020304);
        rd(6'd63, 32'hDEADBEEF);
        rd(6'd0, 32'h01020304);
        idle();
        drain("top");

        // Reset in the middle of a clear.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_do_oreg0", do_a, 32'h0);
        check("midrst_do_oreg1", do_b, 32'h0);
        check("midrst_vld_oreg1", {31'b0, vld_b}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (busy_a && n < 200) begin
            en0 = (n == 0) || (n >= 40 && n <= 50);
            we0 = 4'b1111;
            a0  = (n == 0) ? 6'd63 : 6'd1;
            di0 = (n == 0) ? 32'hFFFFFFFF : 32'hCAFEF00D;
            n++;
            @(negedge clk);
        end
        en0 = 1'b0;
        check("midrst_busy_cycles", n, 32'd64);
        rd(6'd63, 32'h0);
        rd(6'd1, 32'h0);
        rd(6'd7, 32'h0);
        idle();
        drain("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
